alu_writeback: RTL and testbench

- Execute-to-register-file writeback stage that sits directly downstream of the ALU and consumes its 32-bit result.
- Buffers up to two ALU results in a 2-entry FIFO with a valid/ready input handshake.
- Drains the FIFO to the register-file write port, which may stall the stage through a write-acknowledge.
- Exposes a lookup port so upstream hazard logic can forward pending results before they are written.

---
 rtl/alu_writeback.sv | 130 +++++++++++++
 tb/tb_alu_writeback.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry result FIFO draining to the register-file write port,
// with a forwarding lookup. Define ALU_WB_FLAGS_EN to build the zero/negative flag registers.
module alu_writeback #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic                  rf_wack,
  input  logic [REG_ADDR_W-1:0] lookup_rs,
  output logic                  lookup_hit,
  output logic [DATA_W-1:0]     lookup_data,
  output logic                  busy,
  output logic [31:0]           retired_count,
  output logic                  flag_z,
  output logic                  flag_n
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     result;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        retired_q, retired_d;
  logic               push, pop;
  logic               head_x0;
  logic [CNT_W-1:0]   wr_idx;

  assign head_x0  = (ent_q[0].rd == '0);
  assign in_ready = !rst && (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && (rf_wack || head_x0);

  assign rf_we         = !rst && (count_q != '0) && !head_x0;
  assign rf_waddr      = ent_q[0].rd;
  assign rf_wdata      = ent_q[0].result;
  assign busy          = (count_q != '0);
  assign retired_count = retired_q;

  // Head is always slot 0: a pop shifts the tail forward, a push lands behind what remains.
  always_comb begin
    ent_d     = ent_q;
    count_d   = count_q;
    retired_d = retired_q;
    wr_idx    = pop ? CNT_W'(count_q - CNT_W'(1)) : count_q;
    if (pop) begin
      ent_d[0]  = ent_q[1];
      retired_d = retired_q + 32'd1;
    end
    if (push) begin
      if (wr_idx == '0) ent_d[0] = '{rd: in_rd, result: in_result};
      else              ent_d[1] = '{rd: in_rd, result: in_result};
    end
    count_d = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      retired_q <= '0;
      ent_q[0]  <= '0;
      ent_q[1]  <= '0;
    end else begin
      count_q   <= count_d;
      retired_q <= retired_d;
      ent_q[0]  <= ent_d[0];
      ent_q[1]  <= ent_d[1];
    end
  end

  // Forwarding search over buffered entries; the younger tail overrides the head.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (lookup_rs != '0) begin
      if ((count_q != '0) && (ent_q[0].rd == lookup_rs)) begin
        lookup_hit  = 1'b1;
        lookup_data = ent_q[0].result;
      end
      if ((count_q == CNT_W'(DEPTH)) && (ent_q[1].rd == lookup_rs)) begin
        lookup_hit  = 1'b1;
        lookup_data = ent_q[1].result;
      end
    end
  end

`ifdef ALU_WB_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_n_q, flag_n_d;

  always_comb begin
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (pop) begin
      flag_z_d = (ent_q[0].result == '0);
      flag_n_d = ent_q[0].result[DATA_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized scoreboard bench for alu_writeback against a queue-based reference model.
module tb_alu_writeback;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        rf_we, rf_wack;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  lookup_rs;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        busy;
  logic [31:0] retired_count;
  logic        flag_z, flag_n;

  alu_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wack(rf_wack),
    .lookup_rs(lookup_rs), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .busy(busy), .retired_count(retired_count), .flag_z(flag_z), .flag_n(flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } ent_t;

  ent_t        mq[$];     // reference FIFO contents
  ent_t        exp_q[$];  // expected register-file writes, in order
  int unsigned m_ret;
  bit          m_z, m_n;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: advances on each rising edge from the inputs applied before it.
  always @(posedge clk) begin
    bit   do_push;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_ret = 0;
      m_z   = 1'b0;
      m_n   = 1'b0;
    end else begin
      do_push = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && (rf_wack || mq[0].rd == 5'd0)) begin
        m_z = (mq[0].res == 32'd0);
        m_n = mq[0].res[31];
        void'(mq.pop_front());
        m_ret = m_ret + 1;
      end
      if (do_push) begin
        e.rd  = in_rd;
        e.res = in_result;
        mq.push_back(e);
        if (in_rd != 5'd0) exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares every observable output mid-cycle against the model.
  always @(negedge clk) begin
    bit          e_we, e_hit, e_z, e_n;
    logic [31:0] e_data;
    e_we   = !rst && mq.size() > 0 && mq[0].rd != 5'd0;
    e_hit  = 1'b0;
    e_data = 32'd0;
    if (lookup_rs != 5'd0)
      foreach (mq[i])
        if (mq[i].rd == lookup_rs) begin
          e_hit  = 1'b1;
          e_data = mq[i].res;
        end
`ifdef ALU_WB_FLAGS_EN
    e_z = m_z;
    e_n = m_n;
`else
    e_z = 1'b0;
    e_n = 1'b0;
`endif
    check("in_ready", 32'(in_ready), 32'(!rst && mq.size() < 2));
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("busy", 32'(busy), 32'(mq.size() > 0));
    check("retired_count", retired_count, m_ret);
    check("lookup_hit", 32'(lookup_hit), 32'(e_hit));
    check("lookup_data", lookup_data, e_data);
    check("flag_z", 32'(flag_z), 32'(e_z));
    check("flag_n", 32'(flag_n), 32'(e_n));
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write at %0t: got addr %h data %h expected none", $time, rf_waddr, rf_wdata);
      end else begin
        check("rf_waddr", 32'(rf_waddr), 32'(exp_q[0].rd));
        check("rf_wdata", rf_wdata, exp_q[0].res);
        if (rf_wack) void'(exp_q.pop_front());
      end
    end
    // Everything still pending is discarded by the coming reset edge.
    if (rst) exp_q.delete();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] res, input logic [4:0] rd, input bit wack);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    rf_wack   = wack;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    lookup_rs = 5'd0;
    step();
    step();
    rst = 1'b0;

    // Single result with immediate acknowledge.
    drive(1'b1, 32'h0000_002A, 5'd3, 1'b1);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b1);
    repeat (3) step();

    // Back-to-back pushes into a stalled register file, then drain.
    drive(1'b1, 32'hA0A0_0001, 5'd4, 1'b0); step();
    drive(1'b1, 32'hA0A0_0002, 5'd5, 1'b0); step();
    drive(1'b1, 32'hA0A0_0003, 5'd6, 1'b0); step();
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    repeat (2) step();
    rf_wack = 1'b1;
    repeat (4) step();

    // x0 destination retires without a write even while stalled.
    drive(1'b1, 32'h0000_0055, 5'd0, 1'b0); step();
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    repeat (2) step();

    // Forwarding: youngest of two matching entries wins; rs=0 never hits.
    drive(1'b1, 32'h0000_0011, 5'd7, 1'b0); step();
    drive(1'b1, 32'h0000_0022, 5'd7, 1'b0); step();
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    lookup_rs = 5'd7; step();
    lookup_rs = 5'd0; step();

    // Reset with a full FIFO: neither entry may ever be written.
    rst = 1'b1; step();
    rst = 1'b0;
    rf_wack = 1'b1;
    repeat (3) step();

    // Flag sources: zero then negative.
    drive(1'b1, 32'h0000_0000, 5'd0, 1'b1); step();
    drive(1'b1, 32'h8000_0000, 5'd0, 1'b1); step();
    drive(1'b0, 32'd0, 5'd0, 1'b1);
    repeat (3) step();

    // Randomized traffic with stalls, x0 writes, lookups and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      case ($urandom_range(0, 3))
        0:       r = 32'd0;
        1:       r = 32'h8000_0000 | 32'($urandom_range(0, 255));
        default: r = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, r, 5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
      lookup_rs = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    rst = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 1'b1);
    repeat (6) step();
    check("drain_pending_writes", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
